// File: rtl/seq_div_4bit.sv
// Iterative restoring divider for two's-complement operands: one trial subtract per clock.
// Optional DIV_EARLY_EXIT_EN: skip iteration when |dividend| < |divisor|.
module seq_div_4bit #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             Error
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] QMin = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {StIdle, StDiv, StFix} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   count_q, count_d;
  logic [WIDTH-1:0]  prem_q, prem_d;
  logic [WIDTH-1:0]  sreg_q, sreg_d;
  logic [WIDTH-1:0]  dvs_mag_q, dvs_mag_d;
  logic              sign_dd_q, sign_dd_d;
  logic              sign_dv_q, sign_dv_d;
  logic              dz_q, dz_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [WIDTH-1:0]  quo_q, quo_d;
  logic [WIDTH-1:0]  rem_q, rem_d;

  logic [WIDTH-1:0]  dd_mag, dv_mag;
  logic              short_cut;
  logic [WIDTH:0]    shifted, trial;
  logic              q_neg, q_ovf;
  logic [WIDTH-1:0]  q_fix, r_fix;

  // -2^(WIDTH-1) negates to itself, which is the correct unsigned magnitude.
  assign dd_mag = dividend[WIDTH-1] ? -dividend : dividend;
  assign dv_mag = divisor[WIDTH-1] ? -divisor : divisor;

`ifdef DIV_EARLY_EXIT_EN
  assign short_cut = (divisor == '0) || (dd_mag < dv_mag);
`else
  assign short_cut = (divisor == '0);
`endif

  assign shifted = {prem_q, sreg_q[WIDTH-1]};
  assign trial   = shifted - {1'b0, dvs_mag_q};

  assign q_neg = sign_dd_q ^ sign_dv_q;
  assign q_fix = q_neg ? -sreg_q : sreg_q;
  assign r_fix = sign_dd_q ? -prem_q : prem_q;
  // Only a positive quotient of magnitude 2^(WIDTH-1) is unrepresentable.
  assign q_ovf = !q_neg && (sreg_q == QMin);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (start) state_d = short_cut ? StFix : StDiv;
      StDiv:  if (count_q == CntW'(1)) state_d = StFix;
      StFix:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    count_d   = count_q;
    prem_d    = prem_q;
    sreg_d    = sreg_q;
    dvs_mag_d = dvs_mag_q;
    sign_dd_d = sign_dd_q;
    sign_dv_d = sign_dv_q;
    dz_d      = dz_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    err_d     = err_q;
    quo_d     = quo_q;
    rem_d     = rem_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          sign_dd_d = dividend[WIDTH-1];
          sign_dv_d = divisor[WIDTH-1];
          dvs_mag_d = dv_mag;
          dz_d      = (divisor == '0);
          busy_d    = 1'b1;
          count_d   = CntW'(WIDTH);
          if (short_cut) begin
            // Quotient 0, remainder magnitude = |dividend|, so FIX rebuilds the dividend.
            prem_d = dd_mag;
            sreg_d = '0;
          end else begin
            prem_d = '0;
            sreg_d = dd_mag;
          end
        end
      end
      StDiv: begin
        if (trial[WIDTH]) begin
          prem_d = shifted[WIDTH-1:0];
          sreg_d = {sreg_q[WIDTH-2:0], 1'b0};
        end else begin
          prem_d = trial[WIDTH-1:0];
          sreg_d = {sreg_q[WIDTH-2:0], 1'b1};
        end
        count_d = count_q - CntW'(1);
      end
      StFix: begin
        quo_d  = dz_q ? '1 : q_fix;
        rem_d  = r_fix;
        err_d  = dz_q | q_ovf;
        done_d = 1'b1;
        busy_d = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q   <= '0;
      prem_q    <= '0;
      sreg_q    <= '0;
      dvs_mag_q <= '0;
      sign_dd_q <= 1'b0;
      sign_dv_q <= 1'b0;
      dz_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      quo_q     <= '0;
      rem_q     <= '0;
    end else begin
      count_q   <= count_d;
      prem_q    <= prem_d;
      sreg_q    <= sreg_d;
      dvs_mag_q <= dvs_mag_d;
      sign_dd_q <= sign_dd_d;
      sign_dv_q <= sign_dv_d;
      dz_q      <= dz_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
      quo_q     <= quo_d;
      rem_q     <= rem_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign quotient  = quo_q;
  assign remainder = rem_q;
  assign Error     = err_q;

endmodule

// File: tb/tb_seq_div_4bit.sv
// Self-checking bench for seq_div_4bit: directed steps plus a scoreboard of expected results.
module tb_seq_div_4bit;

`ifdef DIV_EARLY_EXIT_EN
  localparam bit Early = 1'b1;
`else
  localparam bit Early = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [3:0] dividend = '0;
  logic [3:0] divisor = '0;
  logic       busy, done, Error;
  logic [3:0] quotient, remainder;

  int total = 0;
  int bad = 0;
  int n = 0;

  typedef struct {
    logic [3:0] q;
    logic [3:0] r;
    logic       e;
    int         lat;
    string      tag;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  seq_div_4bit #(.WIDTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
    .Error     (Error)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic [3:0] q, input logic [3:0] r, input logic e,
                          input int lat, input string tag);
    exp_t x;
    x.q = q; x.r = r; x.e = e; x.lat = lat; x.tag = tag;
    sb.push_back(x);
  endtask

  // Reference built on integer division: truncates toward zero, remainder follows dividend.
  task automatic push_model(input logic [3:0] dd, input logic [3:0] dv, input string tag);
    logic signed [3:0] sdd, sdv;
    int a, b, qi, ri, lat;
    sdd = dd; sdv = dv;
    a = sdd; b = sdv;
    if (b == 0) begin
      push_exp(4'hF, dd, 1'b1, 1, tag);
    end else begin
      qi = a / b;
      ri = a % b;
      lat = 5;
      if (Early && ((a < 0 ? -a : a) < (b < 0 ? -b : b))) lat = 1;
      push_exp(qi[3:0], ri[3:0], qi == 8, lat, tag);
    end
  endtask

  task automatic launch(input logic [3:0] dd, input logic [3:0] dv);
    @(negedge clk);
    dividend = dd;
    divisor  = dv;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    n = 0;
    chk("busy_after_accept", busy, 1);
  endtask

  task automatic await_result();
    exp_t x;
    while (n < 20) begin
      @(posedge clk);
      #1;
      n++;
      if (done) break;
      chk("busy_while_running", busy, 1);
    end
    x = sb.pop_front();
    chk({x.tag, "_latency"}, n, x.lat);
    chk({x.tag, "_quotient"}, quotient, x.q);
    chk({x.tag, "_remainder"}, remainder, x.r);
    chk({x.tag, "_error"}, Error, x.e);
    chk({x.tag, "_busy_at_done"}, busy, 0);
    @(posedge clk);
    #1;
    chk({x.tag, "_done_single"}, done, 0);
  endtask

  task automatic count_dones(input int cycles, output int cnt);
    cnt = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1;
      if (done) cnt++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    logic [3:0] dd, dv;
    logic [3:0] edge_dd [6];
    logic [3:0] edge_dv [6];
    edge_dd = '{4'h8, 4'h8, 4'h7, 4'hF, 4'h0, 4'h8};
    edge_dv = '{4'h1, 4'h8, 4'h8, 4'h8, 4'h3, 4'h7};

    // Reset state
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_quotient", quotient, 0);
    chk("reset_remainder", remainder, 0);
    chk("reset_error", Error, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // 7 / 2
    push_exp(4'b0011, 4'b0001, 1'b0, 5, "t1_7div2");
    launch(4'd7, 4'd2);
    await_result();

    // Mixed signs
    push_exp(4'b1101, 4'b1111, 1'b0, 5, "t2_m7div2");
    launch(4'b1001, 4'b0010);
    await_result();
    push_exp(4'b1101, 4'b0001, 1'b0, 5, "t2_7divm2");
    launch(4'b0111, 4'b1110);
    await_result();

    // Divide by zero
    push_exp(4'b1111, 4'b0101, 1'b1, 1, "t3_dz");
    launch(4'b0101, 4'b0000);
    await_result();

    // Quotient overflow and most-negative dividend
    push_exp(4'b1000, 4'b0000, 1'b1, 5, "t4_m8divm1");
    launch(4'b1000, 4'b1111);
    await_result();
    push_exp(4'b1100, 4'b0000, 1'b0, 5, "t4_m8div2");
    launch(4'b1000, 4'b0010);
    await_result();

    // start during busy is ignored
    push_exp(4'd2, 4'd0, 1'b0, 5, "t5_6div3");
    launch(4'd6, 4'd3);
    start = 1'b1;
    dividend = 4'd1;
    divisor = 4'd1;
    @(posedge clk);
    #1;
    n = 1;
    start = 1'b0;
    chk("t5_busy_during_pulse", busy, 1);
    await_result();
    count_dones(8, cnt);
    chk("t5_no_extra_done", cnt, 0);

    // Asynchronous reset in the middle of a division
    launch(4'd7, 4'd1);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_done", done, 0);
    chk("t5_rst_quotient", quotient, 0);
    chk("t5_rst_remainder", remainder, 0);
    chk("t5_rst_error", Error, 0);
    @(negedge clk);
    rst_n = 1'b1;
    count_dones(10, cnt);
    chk("t5_no_done_after_rst", cnt, 0);

    // |dividend| < |divisor|
    push_exp(4'd0, 4'd3, 1'b0, Early ? 1 : 5, "t6_3div5");
    launch(4'd3, 4'd5);
    await_result();

    // Boundary operands against the model
    for (int i = 0; i < 6; i++) begin
      push_model(edge_dd[i], edge_dv[i], "edge");
      launch(edge_dd[i], edge_dv[i]);
      await_result();
    end

    // Random operands against the model
    for (int i = 0; i < 16; i++) begin
      dd = 4'($urandom_range(0, 15));
      dv = 4'($urandom_range(0, 15));
      push_model(dd, dv, "rand");
      launch(dd, dv);
      await_result();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
